// File: rtl/pipe_height_gen.sv
// Gap-height generator for the Flappy pipes: each channel gets a new height from a 16-bit Galois LFSR
// whenever its pipe reaches position 0. Define PIPE_HEIGHT_SMOOTH_EN to limit the jump between heights.
module pipe_height_gen #(
    parameter int NUM_PIPES  = 2,
    parameter int HEIGHT_W   = 16,
    parameter int POS_W      = 16,
    parameter int MIN_GAP_Y  = 40,
    parameter int STEP       = 20,
    parameter int LEVELS     = 7,
    parameter int SEQ_LEN    = 50,
    parameter int END_HEIGHT = 395,
    parameter int WRAP       = 0,
    parameter int MAX_DELTA  = 60
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          tick,
    input  logic                          Button,
    input  logic [NUM_PIPES*POS_W-1:0]    pipe_pos,
    output logic [NUM_PIPES*HEIGHT_W-1:0] pipe_height,
    output logic                          started,
    output logic                          done,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int                  CNT_W      = $clog2(SEQ_LEN + 1);
    localparam logic [HEIGHT_W-1:0] MIN_H      = HEIGHT_W'(MIN_GAP_Y);
    localparam logic [HEIGHT_W-1:0] MAX_H      = HEIGHT_W'(MIN_GAP_Y + STEP * (LEVELS - 1));
    localparam logic [HEIGHT_W-1:0] RST_H      = HEIGHT_W'(MIN_GAP_Y + STEP * ((LEVELS - 1) / 2));
    localparam logic [HEIGHT_W-1:0] END_H      = HEIGHT_W'(END_HEIGHT);
    localparam logic [HEIGHT_W-1:0] STEP_H     = HEIGHT_W'(STEP);
    localparam logic [HEIGHT_W:0]   DELTA_X    = (HEIGHT_W + 1)'(MAX_DELTA);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]    CNT_END    = CNT_W'(SEQ_LEN);
    localparam logic [15:0]         LFSR_SEED  = 16'hACE1;
    localparam logic [15:0]         LFSR_TAPS  = 16'hB400;
`ifdef PIPE_HEIGHT_SMOOTH_EN
    localparam bit                  SMOOTH_EN  = 1'b1;
`else
    localparam bit                  SMOOTH_EN  = 1'b0;
`endif

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_lfsr;
    logic [15:0]           w_lfsr_next;
    logic [HEIGHT_W-1:0]   r_height      [NUM_PIPES];
    logic [HEIGHT_W-1:0]   w_height_next [NUM_PIPES];
    logic [CNT_W-1:0]      r_cnt         [NUM_PIPES];
    logic [CNT_W-1:0]      w_cnt_next    [NUM_PIPES];
    logic [HEIGHT_W-1:0]   w_rand        [NUM_PIPES];
    logic [HEIGHT_W-1:0]   w_new         [NUM_PIPES];
    logic [NUM_PIPES-1:0]  r_prev_zero;
    logic [NUM_PIPES-1:0]  w_prev_zero_next;
    logic [NUM_PIPES-1:0]  r_fin;
    logic [NUM_PIPES-1:0]  w_fin_next;
    logic [NUM_PIPES-1:0]  w_zero;
    logic [NUM_PIPES-1:0]  w_arrival;
    logic                  r_started;
    logic                  w_started_next;
    logic                  r_done;
    logic                  w_done_next;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // Each channel reads its own rotation of the shared LFSR so simultaneous arrivals differ.
    function automatic logic [HEIGHT_W-1:0] level_height(input logic [15:0] v, input int k);
        logic [7:0] b;
        logic [7:0] lvl;
        b   = 8'({v, v} >> (4 * k));
        lvl = 8'({24'd0, b} % 32'(LEVELS));
        return MIN_H + STEP_H * HEIGHT_W'(lvl);
    endfunction

    // One extra bit keeps prev+MAX_DELTA from wrapping before the clamp.
    function automatic logic [HEIGHT_W-1:0] smooth(input logic [HEIGHT_W-1:0] rnd,
                                                   input logic [HEIGHT_W-1:0] prev);
        logic [HEIGHT_W:0] v;
        logic [HEIGHT_W:0] hi;
        logic [HEIGHT_W:0] lo;
        v  = {1'b0, rnd};
        hi = {1'b0, prev} + DELTA_X;
        lo = ({1'b0, prev} > DELTA_X) ? ({1'b0, prev} - DELTA_X) : '0;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        if (v > {1'b0, MAX_H}) v = {1'b0, MAX_H};
        if (v < {1'b0, MIN_H}) v = {1'b0, MIN_H};
        return v[HEIGHT_W-1:0];
    endfunction

    for (genvar k = 0; k < NUM_PIPES; k++) begin : g_ch
        assign w_zero[k]    = (pipe_pos[k*POS_W +: POS_W] == '0);
        assign w_arrival[k] = tick & w_zero[k] & ~r_prev_zero[k];
        assign w_rand[k]    = level_height(r_lfsr, k);
        assign w_new[k]     = SMOOTH_EN ? smooth(w_rand[k], r_height[k]) : w_rand[k];
        assign pipe_height[k*HEIGHT_W +: HEIGHT_W] = r_height[k];
    end

    always_comb begin
        w_state_next     = r_state;
        w_lfsr_next      = r_lfsr;
        w_started_next   = r_started;
        w_done_next      = r_done;
        w_fin_next       = r_fin;
        w_prev_zero_next = r_prev_zero;
        for (int k = 0; k < NUM_PIPES; k++) begin
            w_height_next[k] = r_height[k];
            w_cnt_next[k]    = r_cnt[k];
        end

        if (tick) begin
            w_prev_zero_next = w_zero;
        end

        case (r_state)
            S_IDLE: begin
                if (tick) begin
                    w_lfsr_next = lfsr_step(r_lfsr);
                    if (!Button) begin
                        w_state_next   = S_RUN;
                        w_started_next = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (|w_arrival) begin
                    w_lfsr_next = lfsr_step(r_lfsr);
                end
                for (int k = 0; k < NUM_PIPES; k++) begin
                    if (w_arrival[k] && !r_fin[k]) begin
                        if (r_cnt[k] == CNT_LAST) begin
                            if (WRAP == 0) begin
                                w_height_next[k] = END_H;
                                w_fin_next[k]    = 1'b1;
                                w_cnt_next[k]    = CNT_END;
                            end else begin
                                w_height_next[k] = w_new[k];
                                w_cnt_next[k]    = '0;
                            end
                        end else begin
                            w_height_next[k] = w_new[k];
                            w_cnt_next[k]    = r_cnt[k] + CNT_W'(1);
                        end
                    end
                end
                if (&w_fin_next) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end
            end
            S_DONE: begin
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_started   <= 1'b0;
            r_done      <= 1'b0;
            r_fin       <= '0;
            r_prev_zero <= '1;
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_height[k] <= RST_H;
                r_cnt[k]    <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_started   <= w_started_next;
            r_done      <= w_done_next;
            r_fin       <= w_fin_next;
            r_prev_zero <= w_prev_zero_next;
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_height[k] <= w_height_next[k];
                r_cnt[k]    <= w_cnt_next[k];
            end
        end
    end

    assign started   = r_started;
    assign done      = r_done;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_pipe_height_gen.sv
// Bench for pipe_height_gen: a WRAP=0 and a WRAP=1 instance share random stimulus and are
// compared every cycle against an arithmetic model of the height rules.
module tb_pipe_height_gen;

    localparam int NP   = 2;
    localparam int HW   = 16;
    localparam int PW   = 16;
    localparam int SEQ  = 50;
    localparam int ENDH = 395;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst0, rst1, tick, button;
    logic [NP*PW-1:0]  pos;
    logic [NP*HW-1:0]  h0, h1;
    logic              st0, st1, dn0, dn1;
    logic [1:0]        sd0, sd1;

    pipe_height_gen #(.NUM_PIPES(NP), .WRAP(0)) u_dut0 (
        .clk(clk), .Reset(rst0), .tick(tick), .Button(button), .pipe_pos(pos),
        .pipe_height(h0), .started(st0), .done(dn0), .state_dbg(sd0)
    );
    pipe_height_gen #(.NUM_PIPES(NP), .WRAP(1)) u_dut1 (
        .clk(clk), .Reset(rst1), .tick(tick), .Button(button), .pipe_pos(pos),
        .pipe_height(h1), .started(st1), .done(dn1), .state_dbg(sd1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode    [2];
    logic [15:0] m_lfsr    [2];
    int          m_h       [2][NP];
    int          m_cnt     [2][NP];
    bit          m_prev    [2][NP];
    bit          m_fin     [2][NP];
    bit          m_upd     [2][NP];
    bit          m_started [2];
    bit          m_done    [2];
    int          m_served  [2];
    bit          m_valid = 1'b0;

    function automatic logic [15:0] f_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int f_rand_h(input logic [15:0] v, input int k);
        logic [31:0] d;
        int b;
        d = {v, v} >> (4 * k);
        b = int'(d[7:0]);
        return 40 + 20 * (b % 7);
    endfunction

    function automatic int f_next_h(input logic [15:0] v, input int k, input int prev);
        int r;
        r = f_rand_h(v, k);
`ifdef PIPE_HEIGHT_SMOOTH_EN
        if (r > prev + 60) r = prev + 60;
        if (r < prev - 60) r = prev - 60;
        if (r > 160) r = 160;
        if (r < 40) r = 40;
`endif
        return r;
    endfunction

    task automatic model_step(input int i, input bit rst);
        logic [15:0] old;
        bit          arr [NP];
        bit          any;
        bit          all_fin;
        bit          z;
        for (int k = 0; k < NP; k++) m_upd[i][k] = 1'b0;
        if (rst) begin
            m_mode[i] = M_IDLE; m_lfsr[i] = 16'hACE1;
            m_started[i] = 1'b0; m_done[i] = 1'b0; m_served[i] = 0;
            for (int k = 0; k < NP; k++) begin
                m_h[i][k] = 100; m_cnt[i][k] = 0; m_prev[i][k] = 1'b1; m_fin[i][k] = 1'b0;
            end
            return;
        end
        if (!tick) return;
        old = m_lfsr[i];
        any = 1'b0;
        for (int k = 0; k < NP; k++) begin
            z = (pos[k*PW +: PW] == 0);
            arr[k] = z && !m_prev[i][k];
            m_prev[i][k] = z;
            any = any | arr[k];
        end
        if (m_mode[i] == M_IDLE) begin
            m_lfsr[i] = f_step(old);
            if (!button) begin
                m_mode[i] = M_RUN;
                m_started[i] = 1'b1;
            end
        end else if (m_mode[i] == M_RUN) begin
            if (any) m_lfsr[i] = f_step(old);
            for (int k = 0; k < NP; k++) begin
                if (arr[k] && !m_fin[i][k]) begin
                    m_served[i]++;
                    m_upd[i][k] = 1'b1;
                    if (i == 0 && m_cnt[i][k] == SEQ - 1) begin
                        m_h[i][k] = ENDH; m_fin[i][k] = 1'b1; m_cnt[i][k] = SEQ;
                    end else begin
                        m_h[i][k] = f_next_h(old, k, m_h[i][k]);
                        m_cnt[i][k] = (m_cnt[i][k] == SEQ - 1) ? 0 : m_cnt[i][k] + 1;
                    end
                end
            end
            all_fin = 1'b1;
            for (int k = 0; k < NP; k++) all_fin = all_fin & m_fin[i][k];
            if (all_fin) begin
                m_mode[i] = M_DONE;
                m_done[i] = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, rst0);
            model_step(1, rst1);
            if (rst0 && rst1) m_valid = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int last_h [2][NP];
    int jumps = 0;

    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < NP; k++) begin
                        a = (i == 0) ? int'(h0[k*HW +: HW]) : int'(h1[k*HW +: HW]);
                        check_int($sformatf("height_i%0d_k%0d", i, k), a, m_h[i][k]);
                        if (i == 1) check_int($sformatf("range_i1_k%0d", k), int'(a >= 40 && a <= 160 && (a % 20) == 0), 1);
`ifdef PIPE_HEIGHT_SMOOTH_EN
                        if (m_upd[i][k] && m_h[i][k] != ENDH)
                            check_int($sformatf("delta_i%0d_k%0d", i, k), int'((a - last_h[i][k] <= 60) && (last_h[i][k] - a <= 60)), 1);
`else
                        if (m_upd[i][k] && last_h[i][k] == 40 && a == 160) jumps++;
`endif
                        last_h[i][k] = a;
                    end
                    check_int($sformatf("started_i%0d", i), (i == 0) ? int'(st0) : int'(st1), int'(m_started[i]));
                    check_int($sformatf("done_i%0d", i),    (i == 0) ? int'(dn0) : int'(dn1), int'(m_done[i]));
                    check_int($sformatf("state_i%0d", i),   (i == 0) ? int'(sd0) : int'(sd1), m_mode[i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_pos(input int k, input int v);
        pos[k*PW +: PW] = PW'(v);
    endtask

    task automatic do_tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] lb;
        int          ph [NP];
        bit          did_rst1;
        bit          fin_ok;
        bit          pulse;
        int          cyc;

        rst0 = 1'b1; rst1 = 1'b1; tick = 1'b0; button = 1'b1;
        pos = '0;
        for (int k = 0; k < NP; k++) set_pos(k, 100);
        do_tick(3);

        // Pin the model against hand-computed values.
        check_int("pin_lfsr_step", int'(f_step(16'hACE1)), 16'hE270);
        check_int("pin_level_k0", f_rand_h(16'hACE1, 0), 60);
        check_int("pin_level_k1", f_rand_h(16'hACE1, 1), 100);
        check_int("pin_level_k3_wrap", f_rand_h(16'hACE1, 3), 140);

        check_int("reset_h0_k0", int'(h0[0 +: HW]), 100);
        check_int("reset_h0_k1", int'(h0[HW +: HW]), 100);
        check_int("reset_started", int'(st0), 0);
        check_int("reset_done", int'(dn0), 0);
        check_int("reset_state", int'(sd0), 0);

        // Idle ticks 1..4 with pipe 0 toggling through 0: heights must hold.
        rst0 = 1'b0; rst1 = 1'b0; tick = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            set_pos(0, (t % 2 == 1) ? 0 : 50);
            do_tick(1);
        end
        check_int("idle_hold_k0", int'(h0[0 +: HW]), 100);
        check_int("idle_hold_k1", int'(h0[HW +: HW]), 100);

        // Tick 5: press.
        button = 1'b0;
        do_tick(1);
        button = 1'b1;
        check_int("press_started", int'(st0), 1);

        // First arrival on pipe 0.
        set_pos(0, 0);
        do_tick(1);
        check_int("first_height_in_set",
                  int'(h0[0 +: HW] >= 40 && h0[0 +: HW] <= 160 && (h0[0 +: HW] % 20) == 0), 1);

        // Parked at 0: counts once.
        do_tick(10);

        // Both channels arrive together.
        set_pos(0, 77); set_pos(1, 77);
        do_tick(1);
        lb = m_lfsr[0];
        for (int k = 0; k < NP; k++) ph[k] = m_h[0][k];
        set_pos(0, 0); set_pos(1, 0);
        do_tick(1);
        check_int("dual_k0", int'(h0[0 +: HW]), f_next_h(lb, 0, ph[0]));
        check_int("dual_k1", int'(h0[HW +: HW]), f_next_h(lb, 1, ph[1]));

        // Random phase: run instance 0 to completion, reset instance 1 around its 30th arrival.
        did_rst1 = 1'b0;
        fin_ok   = 1'b0;
        for (cyc = 0; cyc < 30000 && !fin_ok; cyc++) begin
            tick   = ($urandom_range(0, 9) != 0);
            button = ($urandom_range(0, 15) != 0);
            for (int k = 0; k < NP; k++)
                set_pos(k, ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 300)));
            pulse = (!did_rst1 && m_served[1] >= 30);
            rst1  = pulse;
            if (pulse) did_rst1 = 1'b1;
            do_tick(1);
            if (pulse) begin
                rst1 = 1'b0;
                check_int("rst1_h_k0", int'(h1[0 +: HW]), 100);
                check_int("rst1_h_k1", int'(h1[HW +: HW]), 100);
                check_int("rst1_state", int'(sd1), 0);
            end
            fin_ok = m_done[0] && did_rst1 && m_served[1] >= 120 && cyc >= 4000;
        end
        check_int("random_phase_complete", int'(fin_ok), 1);
        check_int("final_done0", int'(dn0), 1);
        check_int("final_done1", int'(dn1), 0);

        // Reset from DONE.
        rst0 = 1'b1;
        do_tick(1);
        rst0 = 1'b0;
        check_int("rst_done_h_k0", int'(h0[0 +: HW]), 100);
        check_int("rst_done_state", int'(sd0), 0);
        check_int("rst_done_done", int'(dn0), 0);
        do_tick(2);

`ifndef PIPE_HEIGHT_SMOOTH_EN
        $display("info: 40->160 jumps seen: %0d", jumps);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
